// File: rtl/core_pkg.sv
// Shared types for the core's memory-side blocks: access widths and the
// data-memory access state machine encoding.
package core_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for 32-bit word buses: write enables/replication,
// alignment check and right-alignment of a read word.
module mem_lane_align
  import core_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] rdata_aligned
);

  always_comb begin
    byte_en    = 4'hF;
    wdata      = data;
    misaligned = 1'b0;
    case (mem_width_e'(width))
      BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wdata   = {4{data[7:0]}};
      end
      HALF: begin
        byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      // Width 2'b11 behaves as a word access.
      default: begin
        byte_en    = 4'hF;
        wdata      = data;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

  assign rdata_aligned = rdata >> {addr_lo, 3'b000};

endmodule

// File: rtl/data_mem_access.sv
// Memory-access stage: turns execute-stage load/store requests into word-aligned
// bus transfers, stalls the pipeline while a transfer is outstanding.
module data_mem_access
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [1:0]  load_width,
  input  logic [31:0] load_addr,
  input  logic        store_en,
  input  logic [1:0]  store_width,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] load_data,
  output logic        stall_req,
  output logic        misaligned_load,
  output logic        misaligned_store,
  output logic        bus_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, capture_q;
  logic [3:0]  byte_en_q;
  logic        we_q, discard_q;
  logic [15:0] cnt_q;

  logic        req_valid, req_load, accept, timeout_hit, finish, discard;
  logic [1:0]  req_width, align_addr;
  logic [31:0] req_addr, lane_wdata, rdata_aligned;
  logic [3:0]  lane_byte_en;
  logic        lane_misaligned;

  // Loads win if both enables are raised.
  assign req_load  = load_en;
  assign req_valid = (load_en | store_en) & ~flush;
  assign req_width = load_en ? load_width : store_width;
  assign req_addr  = load_en ? load_addr : store_addr;

  // The aligner sees the incoming address in IDLE and the latched one afterwards.
  assign align_addr = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];

  mem_lane_align u_align (
    .width         (req_width),
    .addr_lo       (align_addr),
    .data          (store_data),
    .rdata         (bus_rdata),
    .byte_en       (lane_byte_en),
    .wdata         (lane_wdata),
    .misaligned    (lane_misaligned),
    .rdata_aligned (rdata_aligned)
  );

  assign accept      = (state_q == IDLE) & req_valid & ~lane_misaligned;
  assign timeout_hit = (state_q == WAIT) & ~bus_ready & (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign finish      = (state_q == WAIT) & (bus_ready | timeout_hit);
  assign discard     = discard_q | flush;

  always_comb begin
    state_d          = state_q;
    stall_req        = 1'b0;
    misaligned_load  = 1'b0;
    misaligned_store = 1'b0;
    bus_timeout      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && lane_misaligned) begin
          misaligned_load  = req_load;
          misaligned_store = ~req_load;
        end else if (accept) begin
          stall_req = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        stall_req   = 1'b1;
        bus_timeout = timeout_hit;
        if (finish) state_d = discard ? IDLE : DONE;
      end
      DONE: begin
        if (flush || !hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      byte_en_q <= '0;
      we_q      <= 1'b0;
      discard_q <= 1'b0;
      capture_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        discard_q <= 1'b0;
        cnt_q     <= '0;
        if (accept) begin
          addr_q    <= req_addr;
          we_q      <= ~req_load;
          byte_en_q <= lane_byte_en;
          wdata_q   <= lane_wdata;
        end
      end
      if (state_q == WAIT) begin
        if (flush) discard_q <= 1'b1;
        if (finish) begin
          cnt_q <= '0;
          // A squashed transfer leaves the previous result untouched.
          if (!discard) capture_q <= (bus_ready && !we_q) ? rdata_aligned : 32'h0;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  assign bus_req     = (state_q == WAIT);
  assign bus_we      = bus_req & we_q;
  assign bus_addr    = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_byte_en = bus_req ? byte_en_q : 4'h0;
  assign bus_wdata   = bus_req ? wdata_q : 32'h0;
  assign load_data   = (state_q == DONE) ? capture_q : 32'h0;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed and randomized checks of data_mem_access against a transaction-level
// model of lane selection, alignment, latency and timeout.
module tb_data_mem_access;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en, store_en, hold, flush, bus_ready;
  logic [1:0]  load_width, store_width;
  logic [31:0] load_addr, store_addr, store_data, bus_rdata;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic        stall_req, misaligned_load, misaligned_store, bus_timeout, bus_req, bus_we;
  logic [3:0]  bus_byte_en;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .rst              (rst),
    .load_en          (load_en),
    .load_width       (load_width),
    .load_addr        (load_addr),
    .store_en         (store_en),
    .store_width      (store_width),
    .store_addr       (store_addr),
    .store_data       (store_data),
    .hold             (hold),
    .flush            (flush),
    .load_data        (load_data),
    .stall_req        (stall_req),
    .misaligned_load  (misaligned_load),
    .misaligned_store (misaligned_store),
    .bus_timeout      (bus_timeout),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_byte_en      (bus_byte_en),
    .bus_wdata        (bus_wdata),
    .bus_ready        (bus_ready),
    .bus_rdata        (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_en = 0; store_en = 0; hold = 0; flush = 0; bus_ready = 0;
    load_width = 0; store_width = 0; load_addr = 0; store_addr = 0;
    store_data = 0; bus_rdata = 0;
  endtask

  task automatic chk_quiet(input string pre);
    chk({pre, "_load_data"}, load_data, 0);
    chk({pre, "_stall"}, {31'd0, stall_req}, 0);
    chk({pre, "_misl"}, {31'd0, misaligned_load}, 0);
    chk({pre, "_miss"}, {31'd0, misaligned_store}, 0);
    chk({pre, "_tmo"}, {31'd0, bus_timeout}, 0);
    chk({pre, "_req"}, {31'd0, bus_req}, 0);
    chk({pre, "_we"}, {31'd0, bus_we}, 0);
    chk({pre, "_addr"}, bus_addr, 0);
    chk({pre, "_be"}, {28'd0, bus_byte_en}, 0);
    chk({pre, "_wdata"}, bus_wdata, 0);
  endtask

  // Reference model: access size in bytes and the lanes it covers.
  function automatic int size_f(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit mis_f(input logic [1:0] w, input logic [31:0] a);
    return (int'(a[1:0]) % size_f(w)) != 0;
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] w, input logic [31:0] a);
    int sz = size_f(w);
    int off = int'(a[1:0]);
    int base = off - (off % sz);
    logic [3:0] be = 4'h0;
    for (int i = 0; i < sz; i++) be[base + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] w, input logic [31:0] d);
    int sz = size_f(w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(d >> (8 * (i % sz)));
    return r;
  endfunction

  // One access: dly = WAIT cycles before bus_ready (>= T means never ready).
  task automatic access(input bit ld, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int dly,
                        input int hold_n);
    bit mis = mis_f(w, a);
    bit tmo = (dly >= int'(T));
    logic [31:0] exp_ld;
    if (ld) begin
      load_en = 1; load_width = w; load_addr = a;
    end else begin
      store_en = 1; store_width = w; store_addr = a; store_data = d;
    end
    #1;
    chk("idle_stall", {31'd0, stall_req}, {31'd0, !mis});
    chk("idle_req", {31'd0, bus_req}, 0);
    chk("idle_misl", {31'd0, misaligned_load}, {31'd0, ld && mis});
    chk("idle_miss", {31'd0, misaligned_store}, {31'd0, !ld && mis});
    chk("idle_load_data", load_data, 0);
    if (mis) begin
      tick();
      clear_inputs();
      #1;
      chk_quiet("mis_after");
      return;
    end
    tick();
    for (int k = 0; k < int'(T); k++) begin
      chk("wait_req", {31'd0, bus_req}, 1);
      chk("wait_stall", {31'd0, stall_req}, 1);
      chk("wait_addr", bus_addr, {a[31:2], 2'b00});
      chk("wait_be", {28'd0, bus_byte_en}, {28'd0, be_f(w, a)});
      chk("wait_we", {31'd0, bus_we}, {31'd0, !ld});
      if (!ld) chk("wait_wdata", bus_wdata, wdata_f(w, d));
      if (k == dly) begin
        bus_ready = 1; bus_rdata = rd;
        #1;
        chk("wait_tmo_ready", {31'd0, bus_timeout}, 0);
        tick();
        bus_ready = 0; bus_rdata = $urandom;
        break;
      end
      #1;
      chk("wait_tmo", {31'd0, bus_timeout}, {31'd0, k == int'(T) - 1});
      tick();
    end
    exp_ld = (ld && !tmo) ? (rd >> (8 * int'(a[1:0]))) : 32'h0;
    for (int h = 0; h <= hold_n; h++) begin
      hold = (h < hold_n);
      #1;
      chk("done_stall", {31'd0, stall_req}, 0);
      chk("done_req", {31'd0, bus_req}, 0);
      chk("done_tmo", {31'd0, bus_timeout}, 0);
      chk("done_load_data", load_data, exp_ld);
      tick();
    end
    clear_inputs();
    #1;
    chk_quiet("idle_after");
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    chk_quiet("reset");

    // Byte store to the top lane, ready in the first WAIT cycle.
    access(0, 2'b00, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0);
    // Halfword load from upper half, ready in the third WAIT cycle.
    access(1, 2'b01, 32'h0000_2002, 32'h0, 32'h8001_1234, 2, 0);
    // Misaligned word load and halfword store.
    access(1, 2'b10, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
    access(0, 2'b01, 32'h0000_0011, 32'h1234_5678, 32'h0, 0, 0);
    // Word load that never sees bus_ready.
    access(1, 2'b10, 32'h0000_4000, 32'h0, 32'hFFFF_FFFF, T, 0);
    // Hold keeps DONE for three extra cycles.
    access(1, 2'b10, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 0, 3);
    // Width 11 acts as a word.
    access(0, 2'b11, 32'h0000_6008, 32'h1122_3344, 32'h0, 1, 0);

    // Flush in the second WAIT cycle; transfer completes, then straight to IDLE.
    load_en = 1; load_width = 2'b10; load_addr = 32'h0000_7000;
    #1;
    chk("fl_idle_stall", {31'd0, stall_req}, 1);
    tick();
    chk("fl_w0_req", {31'd0, bus_req}, 1);
    tick();
    flush = 1; load_en = 0;
    #1;
    chk("fl_w1_req", {31'd0, bus_req}, 1);
    chk("fl_w1_stall", {31'd0, stall_req}, 1);
    tick();
    flush = 0;
    #1;
    chk("fl_w2_req", {31'd0, bus_req}, 1);
    chk("fl_w2_stall", {31'd0, stall_req}, 1);
    tick();
    bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("fl_w3_req", {31'd0, bus_req}, 1);
    chk("fl_w3_tmo", {31'd0, bus_timeout}, 0);
    tick();
    clear_inputs();
    #1;
    chk_quiet("fl_end");
    tick();
    chk_quiet("fl_no_reissue");

    // Reset in WAIT drops everything on the next edge.
    load_en = 1; load_width = 2'b10; load_addr = 32'h0000_8000;
    tick();
    chk("rst_wait_req", {31'd0, bus_req}, 1);
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
    chk_quiet("rst_in_wait");

    for (int n = 0; n < 40; n++) begin
      access(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, T)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
